// File: rtl/reorder_buf_if.sv
// Handshake bundle for the reorder buffer: issue, CDB broadcast and commit.
// The master side is the issue/CDB source; the slave side is the buffer.
interface reorder_buf_if #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic [REG_W-1:0]  issue_dest;
    logic [TAG_W-1:0]  issue_tag;
    logic              issue_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              commit;
    logic [REG_W-1:0]  commit_dest;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;
    logic [CW-1:0]     count;
    logic              empty;

    modport master (
        output issue_valid, issue_dest, issue_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  issue_ready, commit, commit_dest, commit_tag,
        input  commit_data, count, empty
    );

    modport slave (
        input  issue_valid, issue_dest, issue_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output issue_ready, commit, commit_dest, commit_tag,
        output commit_data, count, empty
    );
endinterface

// File: rtl/reorder_buf.sv
// In-order retirement queue capturing CDB results per reservation-station tag.
// Define ROB_CDB_BYPASS_EN to let a waiting head retire straight off the CDB.
module reorder_buf #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    reorder_buf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [REG_W-1:0]  dest_q [DEPTH];
    logic [REG_W-1:0]  dest_d [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              commit_q, commit_d;
    logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
    logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;

    logic issue_fire;
    logic cdb_hit;
    logic head_ok;
    logic head_byp;
    logic retire;

    always_comb begin
        valid_d       = valid_q;
        ready_d       = ready_q;
        dest_d        = dest_q;
        tag_d         = tag_q;
        data_d        = data_q;
        head_d        = head_q;
        tail_d        = tail_q;
        commit_dest_d = commit_dest_q;
        commit_tag_d  = commit_tag_q;
        commit_data_d = commit_data_q;

        issue_fire = bus.issue_valid && (count_q < CW'(DEPTH));
        cdb_hit    = bus.cdb_valid && (bus.cdb_tag != '0);

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_hit && valid_q[i] && !ready_q[i] &&
                tag_q[i] == bus.cdb_tag) begin
                ready_d[i] = 1'b1;
                data_d[i]  = bus.cdb_data;
            end
        end

        head_ok = valid_q[head_q] && ready_q[head_q];
`ifdef ROB_CDB_BYPASS_EN
        head_byp = valid_q[head_q] && !ready_q[head_q] && cdb_hit &&
                   (tag_q[head_q] == bus.cdb_tag);
`else
        head_byp = 1'b0;
`endif
        retire   = head_ok || head_byp;
        commit_d = retire;

        if (retire) begin
            commit_dest_d   = dest_q[head_q];
            commit_tag_d    = tag_q[head_q];
            commit_data_d   = head_ok ? data_q[head_q] : bus.cdb_data;
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + AW'(1);
        end

        // Full buffer blocks issue, so tail never aliases a retiring head.
        if (issue_fire) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            dest_d[tail_q]  = bus.issue_dest;
            tag_d[tail_q]   = bus.issue_tag;
            tail_d          = tail_q + AW'(1);
        end

        count_d = count_q + CW'(issue_fire) - CW'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= '0;
            ready_q       <= '0;
            dest_q        <= '{default: '0};
            tag_q         <= '{default: '0};
            data_q        <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_q      <= 1'b0;
            commit_dest_q <= '0;
            commit_tag_q  <= '0;
            commit_data_q <= '0;
        end else begin
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            dest_q        <= dest_d;
            tag_q         <= tag_d;
            data_q        <= data_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_q      <= commit_d;
            commit_dest_q <= commit_dest_d;
            commit_tag_q  <= commit_tag_d;
            commit_data_q <= commit_data_d;
        end
    end

    assign bus.issue_ready = (count_q < CW'(DEPTH));
    assign bus.empty       = (count_q == '0);
    assign bus.count       = count_q;
    assign bus.commit      = commit_q;
    assign bus.commit_dest = commit_dest_q;
    assign bus.commit_tag  = commit_tag_q;
    assign bus.commit_data = commit_data_q;
endmodule
